tilelink_a_arbiter: RTL and testbench
=====================================

Name: tilelink_a_arbiter

Overview:
- Round-robin arbiter with burst locking for a TileLink-UL A channel shared by M masters in front of one slave port.
- Decides which master drives the shared A channel each cycle.
- Holds the grant for the full length of multi-beat Put bursts, so beats from different masters never interleave.
- Sits between the per-master A-channel skid buffers and the A-channel output register of the M-to-1 interconnect. It is a pure control block: it carries no payload.

Parameters:
- M, 2, number of requesting masters (≥2).
- TL_DW, 32, data bus width in bits; sets beat size = TL_DW/8 bytes.
- TL_SZ, 4, width of the a_size field.
- CNT_W, 12, width of the beat counter; must hold the largest beat count minus 1.

Ports:
- tilelink_clock_i  in  1  clock.
- tilelink_reset_i  in  1  synchronous, active-high reset.
- req_valid  in  M  per-master A valid (after skid buffer).
- req_opcode  in  3*M  per-master a_opcode, master i at [3i+2:3i].
- req_size  in  TL_SZ*M  per-master a_size (log2 bytes).
- dn_ready  in  1  shared A channel can accept a beat this cycle.
- grant  out  M  one-hot grant, combinational.
- grant_idx  out  $clog2(M)  binary index of grant.
- grant_valid  out  1  granted master has valid; fire = grant_valid & dn_ready.
- last_beat  out  1  the current granted beat is the last beat of its message.
- locked  out  1  registered; a burst is in progress.

Behaviour:
- State registers: rr_ptr[$clog2(M)], locked, lock_idx[$clog2(M)], beats_left[CNT_W]. All reset to 0.
- While tilelink_reset_i is high, grant=0, grant_valid=0, last_beat=0, and the state is cleared on the clock edge. Reset mid-burst drops the lock unconditionally.
- Multi-beat test: the message is a burst iff opcode ∈ {0 PutFullData, 1 PutPartialData} and size > $clog2(TL_DW/8). Beat count = 2^size / (TL_DW/8). All other opcodes, including Get=4, are single-beat.
- Unlocked grant (combinational, 0 latency):
  - Pick the first i with req_valid[i] scanning rr_ptr, rr_ptr+1, … mod M.
  - No valid request → grant=0, grant_valid=0, grant_idx=0.
- Locked grant:
  - grant = onehot(lock_idx), independent of other requests.
  - grant_valid = req_valid[lock_idx]. A master dropping valid mid-burst stalls the channel; it does not release the lock. There is no timeout.
- last_beat:
  - Unlocked: 1 when the chosen message is single-beat.
  - Locked: 1 when beats_left == 1.
- Fire, unlocked, single-beat: rr_ptr ← (grant_idx+1) mod M.
- Fire, unlocked, burst first beat: locked ← 1, lock_idx ← grant_idx, beats_left ← beat_count−1. rr_ptr is unchanged.
- Fire, locked, beats_left > 1: beats_left ← beats_left−1.
- Fire, locked, beats_left == 1: locked ← 0, beats_left ← 0, rr_ptr ← (lock_idx+1) mod M.
- No fire: state holds. dn_ready low never changes the grant decision's inputs, so the grant is stable while stalled, as TileLink requires.
- Width rules:
  - Beat count is computed in CNT_W bits.
  - Sizes above 12 (4 KiB) are treated as single-beat; this is a protocol error and is not checked.
  - M not a power of two: the rr_ptr wrap compares against M−1 explicitly.
- Simultaneous requests: only the granted master sees a fire. Others must hold their valid and payload; their skid buffers stall on ~grant.

Decomposition:
- Shared package tl_pkg:
  - opcode localparams (PUT_FULL=0, PUT_PARTIAL=1, GET=4, ACCESS_ACK=0, ACCESS_ACK_DATA=1).
  - function is_burst(opcode, size, TL_DW).
  - function beat_count(size, TL_DW) returning CNT_W bits.
- One sub-module: rr_priority_pick (M requests + rotating base → one-hot + index + any). Reusable for D-channel response arbitration.

Test Plan (M=4, TL_DW=32):
- Reset then all valid=0 → grant=0000, grant_valid=0, locked=0, rr_ptr=0.
- req_valid=1111, all Get size 2, dn_ready=1 for 4 cycles → grant_idx sequence 0,1,2,3; last_beat=1 every cycle; locked stays 0.
- Master 1 PutFull size 4 (4 beats), masters 0/2 valid with Get, rr_ptr=1 → grant_idx=1 for 4 consecutive fires; locked=1 after beat 1; last_beat=1 on beat 4 only; next grant_idx=2.
- Mid-burst (beats_left=2), dn_ready=0 for 3 cycles, then master 1 valid=0 for 2 cycles → grant stays 0010, no state change; burst completes afterwards with exactly 2 more fires.
- tilelink_reset_i asserted with locked=1, beats_left=5 → next cycle locked=0, beats_left=0, rr_ptr=0; with req_valid=1000, grant=1000.
- Master 3 PutPartial size 2 (single beat) and Get size 6 → locked stays 0, last_beat=1, one fire each, and rr_ptr advances after each fire.

Source files
------------

// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - TileLink-UL opcodes and A-channel burst helpers
package tl_pkg;

  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  localparam int TL_CNT_W    = 12;
  localparam int TL_MAX_SIZE = 12;

  // Sizes beyond 4 KiB are a protocol error and deliberately fall through as single-beat.
  function automatic logic is_burst(input logic [2:0] opcode, input int unsigned size,
                                    input int unsigned tl_dw);
    return ((opcode == PUT_FULL) || (opcode == PUT_PARTIAL)) &&
           (size > $clog2(tl_dw / 8)) && (size <= TL_MAX_SIZE);
  endfunction

  // Shift by the size difference so 4 KiB does not overflow the counter width.
  function automatic logic [TL_CNT_W-1:0] beat_count(input int unsigned size,
                                                    input int unsigned tl_dw);
    return TL_CNT_W'(1) << (size - $clog2(tl_dw / 8));
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - first set request at or after a rotating base
module rr_priority_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  int unsigned k;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    k      = 0;
    for (int off = 0; off < N; off++) begin
      k = int'(base) + off;
      if (k >= N) k = k - N;
      if (!any && req[k]) begin
        any       = 1'b1;
        idx       = IW'(k);
        onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tilelink_a_arbiter.sv
// rtl/tilelink_a_arbiter.sv - round-robin A-channel arbiter that locks the grant across Put bursts
module tilelink_a_arbiter
  import tl_pkg::*;
#(
  parameter int M     = 2,
  parameter int TL_DW = 32,
  parameter int TL_SZ = 4,
  parameter int CNT_W = 12
) (
  input  logic                 tilelink_clock_i,
  input  logic                 tilelink_reset_i,
  input  logic [M-1:0]         req_valid,
  input  logic [3*M-1:0]       req_opcode,
  input  logic [TL_SZ*M-1:0]   req_size,
  input  logic                 dn_ready,
  output logic [M-1:0]         grant,
  output logic [$clog2(M)-1:0] grant_idx,
  output logic                 grant_valid,
  output logic                 last_beat,
  output logic                 locked
);

  localparam int IW = $clog2(M);

  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    lock_idx;
  logic [CNT_W-1:0] beats_left;

  logic [M-1:0]     pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [IW-1:0]    sel_idx;
  logic [2:0]       sel_opcode;
  logic [TL_SZ-1:0] sel_size;
  logic             sel_burst;
  logic [CNT_W-1:0] first_left;
  logic             fire;

  rr_priority_pick #(.N(M), .IW(IW)) u_pick (
    .req    (req_valid),
    .base   (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign sel_idx    = locked ? lock_idx : pick_idx;
  assign sel_opcode = req_opcode[3*int'(sel_idx) +: 3];
  assign sel_size   = req_size[TL_SZ*int'(sel_idx) +: TL_SZ];
  assign sel_burst  = is_burst(sel_opcode, 32'(sel_size), TL_DW);
  assign first_left = CNT_W'(beat_count(32'(sel_size), TL_DW)) - CNT_W'(1);

  // Outputs depend only on state and req_valid, so the grant holds while dn_ready is low.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    last_beat   = 1'b0;
    if (!tilelink_reset_i) begin
      if (locked) begin
        grant[lock_idx] = 1'b1;
        grant_idx       = lock_idx;
        grant_valid     = req_valid[lock_idx];
        last_beat       = (beats_left == CNT_W'(1));
      end else if (pick_any) begin
        grant       = pick_onehot;
        grant_idx   = pick_idx;
        grant_valid = 1'b1;
        last_beat   = !sel_burst;
      end
    end
  end

  assign fire = grant_valid & dn_ready;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
    return (p == IW'(M - 1)) ? '0 : p + IW'(1);
  endfunction

  always_ff @(posedge tilelink_clock_i) begin
    if (tilelink_reset_i) begin
      rr_ptr     <= '0;
      locked     <= 1'b0;
      lock_idx   <= '0;
      beats_left <= '0;
    end else if (fire) begin
      if (locked) begin
        if (beats_left == CNT_W'(1)) begin
          locked     <= 1'b0;
          beats_left <= '0;
          rr_ptr     <= next_ptr(lock_idx);
        end else begin
          beats_left <= beats_left - CNT_W'(1);
        end
      end else if (sel_burst) begin
        locked     <= 1'b1;
        lock_idx   <= pick_idx;
        beats_left <= first_left;
      end else begin
        rr_ptr <= next_ptr(pick_idx);
      end
    end
  end

endmodule

// File: tb/tb_tilelink_a_arbiter.sv
// tb/tb_tilelink_a_arbiter.sv - directed vector bench for tilelink_a_arbiter with M=4
module tb_tilelink_a_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [11:0] req_opcode;
  logic [15:0] req_size;
  logic        dn_ready;
  logic [3:0]  grant;
  logic [1:0]  grant_idx;
  logic        grant_valid;
  logic        last_beat;
  logic        locked;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tilelink_a_arbiter #(.M(4), .TL_DW(32), .TL_SZ(4), .CNT_W(12)) dut (
    .tilelink_clock_i (clk),
    .tilelink_reset_i (rst),
    .req_valid        (req_valid),
    .req_opcode       (req_opcode),
    .req_size         (req_size),
    .dn_ready         (dn_ready),
    .grant            (grant),
    .grant_idx        (grant_idx),
    .grant_valid      (grant_valid),
    .last_beat        (last_beat),
    .locked           (locked)
  );

  typedef struct packed {
    logic        rst;
    logic [3:0]  v;
    logic [11:0] opc;
    logic [15:0] sz;
    logic        rdy;
    logic [3:0]  g;
    logic [1:0]  gi;
    logic        gv;
    logic        lb;
    logic        lk;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] v, input logic [11:0] opc,
                     input logic [15:0] sz, input logic rdy, input logic [3:0] g,
                     input logic [1:0] gi, input logic gv, input logic lb, input logic lk);
    vec_t t;
    t = '{rst: r, v: v, opc: opc, sz: sz, rdy: rdy, g: g, gi: gi, gv: gv, lb: lb, lk: lk};
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int fires;
    int cyc;
    logic done;
    logic grant_ok;
    logic lb_early;

    rst = 1'b1; req_valid = '0; req_opcode = 12'h924; req_size = 16'h2222; dn_ready = 1'b0;
    repeat (2) @(posedge clk);

    //    rst v        opc     size     rdy  grant    gi  gv lb lk
    add(0, 4'b0000, 12'h924, 16'h2222, 1, 4'b0000, 0, 0, 0, 0);
    add(0, 4'b1111, 12'h924, 16'h2222, 1, 4'b0001, 0, 1, 1, 0);
    add(0, 4'b1111, 12'h924, 16'h2222, 1, 4'b0010, 1, 1, 1, 0);
    add(0, 4'b1111, 12'h924, 16'h2222, 1, 4'b0100, 2, 1, 1, 0);
    add(0, 4'b1111, 12'h924, 16'h2222, 1, 4'b1000, 3, 1, 1, 0);
    add(0, 4'b0001, 12'h924, 16'h2222, 1, 4'b0001, 0, 1, 1, 0);
    // master 1 PutFull size 4: four beats, masters 0 and 2 waiting with Get
    add(0, 4'b0111, 12'h904, 16'h2242, 1, 4'b0010, 1, 1, 0, 0);
    add(0, 4'b0111, 12'h904, 16'h2242, 1, 4'b0010, 1, 1, 0, 1);
    add(0, 4'b0111, 12'h904, 16'h2242, 0, 4'b0010, 1, 1, 0, 1);
    add(0, 4'b0111, 12'h904, 16'h2242, 0, 4'b0010, 1, 1, 0, 1);
    add(0, 4'b0111, 12'h904, 16'h2242, 0, 4'b0010, 1, 1, 0, 1);
    add(0, 4'b0101, 12'h904, 16'h2242, 1, 4'b0010, 1, 0, 0, 1);
    add(0, 4'b0101, 12'h904, 16'h2242, 1, 4'b0010, 1, 0, 0, 1);
    add(0, 4'b0111, 12'h904, 16'h2242, 1, 4'b0010, 1, 1, 0, 1);
    add(0, 4'b0111, 12'h904, 16'h2242, 1, 4'b0010, 1, 1, 1, 1);
    add(0, 4'b0111, 12'h904, 16'h2242, 0, 4'b0100, 2, 1, 1, 0);
    // master 2 PutFull size 5 (8 beats), reset after three fires
    add(0, 4'b0100, 12'h824, 16'h2522, 1, 4'b0100, 2, 1, 0, 0);
    add(0, 4'b0100, 12'h824, 16'h2522, 1, 4'b0100, 2, 1, 0, 1);
    add(0, 4'b0100, 12'h824, 16'h2522, 1, 4'b0100, 2, 1, 0, 1);
    add(1, 4'b1000, 12'h924, 16'h2222, 1, 4'b0000, 0, 0, 0, 1);
    add(0, 4'b1000, 12'h924, 16'h2222, 0, 4'b1000, 3, 1, 1, 0);
    add(0, 4'b1111, 12'h924, 16'h2222, 1, 4'b0001, 0, 1, 1, 0);
    add(0, 4'b1010, 12'h924, 16'h2222, 0, 4'b0010, 1, 1, 1, 0);
    // master 3 PutPartial size 2 and Get size 6 are single-beat
    add(0, 4'b1000, 12'h324, 16'h2222, 1, 4'b1000, 3, 1, 1, 0);
    add(0, 4'b1001, 12'h924, 16'h6222, 1, 4'b0001, 0, 1, 1, 0);
    add(0, 4'b1000, 12'h924, 16'h6222, 1, 4'b1000, 3, 1, 1, 0);
    add(0, 4'b1001, 12'h924, 16'h2222, 0, 4'b0001, 0, 1, 1, 0);
    add(0, 4'b0000, 12'h924, 16'h2222, 1, 4'b0000, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; req_valid = vecs[i].v; req_opcode = vecs[i].opc;
      req_size = vecs[i].sz; dn_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d grant", i), int'(grant), int'(vecs[i].g));
      chk($sformatf("v%0d grant_idx", i), int'(grant_idx), int'(vecs[i].gi));
      chk($sformatf("v%0d grant_valid", i), int'(grant_valid), int'(vecs[i].gv));
      chk($sformatf("v%0d last_beat", i), int'(last_beat), int'(vecs[i].lb));
      chk($sformatf("v%0d locked", i), int'(locked), int'(vecs[i].lk));
    end

    // 8-beat burst from master 0 under random backpressure, others competing
    fires = 0; done = 1'b0; grant_ok = 1'b1; lb_early = 1'b0; cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      rst = 1'b0; req_valid = (fires == 0) ? 4'b0001 : 4'b1111;
      req_opcode = 12'h920; req_size = 16'h2225;
      dn_ready = 1'($urandom_range(0, 1));
      #1;
      if (grant != 4'b0001) grant_ok = 1'b0;
      if (grant_valid && dn_ready) begin
        fires++;
        if (last_beat) done = 1'b1;
        if (last_beat && fires != 8) lb_early = 1'b1;
      end
      cyc++;
    end
    chk("burst8 completed", int'(done), 1);
    chk("burst8 fires", fires, 8);
    chk("burst8 grant held", int'(grant_ok), 1);
    chk("burst8 early last_beat", int'(lb_early), 0);
    @(negedge clk);
    req_valid = 4'b1111; req_opcode = 12'h924; req_size = 16'h2222; dn_ready = 1'b0;
    #1;
    chk("burst8 unlocked", int'(locked), 0);
    chk("burst8 next grant_idx", int'(grant_idx), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
